maple_in: RTL and testbench
===========================

# maple_in

Maple bus receiver and decoder. It samples the two bus lines (pin1 = SDCKA, pin5 = SDCKB), recognises the start pattern, decodes MSB-first data bytes from alternating falling edges, and recognises the end pattern. Decoded bytes are pushed into the receive FIFO, and frame start, end and error events are reported to the controller. It sits beside the transmitter on the same pins and is held idle while the transmitter drives the bus.

## Interface
Parameters:
- TIMEOUT_TICKS, default 64: number of `tick` pulses with no line edge before an in-frame timeout. Used only with the timeout macro.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- pin1  in  1  raw SDCKA line, asynchronous
- pin5  in  1  raw SDCKB line, asynchronous
- oe  in  1  transmitter output enable; while high the receiver is forced to IDLE
- tick  in  1  bus-time strobe, one clk wide
- fifo_data  out  8  decoded byte
- fifo_push  out  1  one-cycle write strobe
- fifo_full  in  1  FIFO cannot accept a byte
- frame_start  out  1  pulse: valid start pattern accepted
- frame_end  out  1  pulse: clean end pattern accepted
- frame_err  out  1  pulse: frame aborted
- err_code  out  2  code of the last abort, held until the next frame_start
  - 01 bad start
  - 10 misaligned end
  - 11 edge collision or timeout
- overflow  out  1  sticky flag: a byte was dropped on fifo_full; cleared by frame_start

## Operation
- Input conditioning
  - Each line passes through a 2-flop synchronizer, then a registered copy used for edge detection.
  - f1 / f5 are the falling edges of the synchronized pin1 / pin5.
- States: IDLE, START, DATA_A, DATA_B, END_WAIT.
- IDLE
  - f1 while synced pin5 = 1 goes to START and clears the start-pulse count.
  - All other edges are ignored.
- START (pin1 low)
  - Each f5 increments a 3-bit pulse count, which saturates at 7.
  - On the pin1 rising edge: if count = 4, pulse frame_start, clear the bit count and byte register, and go to DATA_A.
  - Otherwise pulse frame_err with code 01 and go to IDLE.
- DATA_A (expects f1)
  - f1 shifts synced pin5 into the byte register (MSB first), increments the bit count, and goes to DATA_B.
  - f5 in this state is a data setup transition and is ignored.
- DATA_B (expects f5)
  - f5 shifts synced pin1 in, increments the bit count, and returns to DATA_A.
  - When the bit count reaches 8, the byte is pushed and the bit count wraps to 0.
  - An f1 in DATA_B (a second f1 with no f5 between) is the end marker:
    - The bit sampled by the previous f1 is discarded.
    - If the bit count before that f1 was 0, go to END_WAIT.
    - Otherwise pulse frame_err with code 10 and go to IDLE.
- END_WAIT
  - On the synced pin5 rising edge, pulse frame_end and go to IDLE.
- Byte push
  - If fifo_full = 0, fifo_push is asserted with fifo_data.
  - If fifo_full = 1, there is no push, overflow is set, and decoding continues.
- Collisions
  - f1 and f5 in the same cycle in any non-IDLE state give frame_err with code 11, then IDLE.
- oe = 1 in any state
  - Go to IDLE next cycle with no pulses; the synchronizers keep running.
- Reset values
  - All outputs are 0 and the state is IDLE.
  - Synchronizer flops reset to 1 (bus idle high).
  - err_code = 00.
- The frame_start, frame_end, frame_err and fifo_push pulses are mutually exclusive in any one cycle.

## Timing
- Pin-to-edge latency: 3 clk. A falling edge on a raw pin is seen as f1/f5 3 cycles later.
- Byte push: fifo_push is high exactly 1 clk, 4 clk after the raw pin5 fall that samples bit 0.
- frame_start and frame_end are each 1 clk, 4 clk after the qualifying raw rising edge.
- frame_err is 1 clk, on the cycle after the offending edge is detected.
- fifo_data is stable from the fifo_push cycle until the next push.
- rst asserted mid-frame: the next cycle is IDLE with no pulses, and the partial byte is lost.

## Configuration
- MAPLE_IN_TIMEOUT_EN defined:
  - A 16-bit counter counts `tick` pulses in START, DATA_A, DATA_B and END_WAIT, and clears on any f1/f5 or line rise.
  - When it reaches TIMEOUT_TICKS: frame_err with code 11, then IDLE.
- Not defined: there is no counter, `tick` is unused, and a stalled frame waits indefinitely until oe or rst.

## Structure
- Package maple_pkg holds:
  - the state enum;
  - START_PULSES = 4;
  - error-code constants ERR_NONE, ERR_START, ERR_ALIGN, ERR_COLL.
- Sub-module maple_line_sync: 2-flop synchronizer plus edge detector for both lines. Outputs are the synced levels, f1, f5, r1 and r5.

## Test plan
- Start pattern (4 pin5 pulses), bytes 0xA5 and 0x3C, end pattern -> frame_start; two pushes with 0xA5 then 0x3C; frame_end; err_code = 00.
- Start with 3 pin5 pulses -> frame_err with err_code = 01; no frame_start; following bits ignored.
- Valid start, 5 data bits, end pattern -> frame_err with err_code = 10; no push.
- fifo_full = 1 during the second byte of a 3-byte frame -> pushes of bytes 1 and 3 only; overflow = 1 until the next frame_start.
- oe = 1 while a full frame is driven -> no pulses; oe dropped mid-frame -> receiver waits in IDLE for a new start.
- With MAPLE_IN_TIMEOUT_EN and TIMEOUT_TICKS = 8: stop toggling after 3 bits -> frame_err with code 11 on the 8th tick; without the macro -> no error.

Source files
------------

// File: rtl/maple_pkg.sv
`default_nettype none
// ============================================================================
// Module   : maple_pkg
// Purpose  : Shared types and constants for the Maple bus receiver.
//            Holds the receiver state encoding, the number of pin5 pulses
//            in a valid start pattern and the 2-bit abort codes.
// Revision : 1.0 - initial release
// ============================================================================
package maple_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_DATA_A   = 3'd2,
        ST_DATA_B   = 3'd3,
        ST_END_WAIT = 3'd4
    } state_t;

    localparam logic [2:0] START_PULSES = 3'd4;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_START = 2'b01;
    localparam logic [1:0] ERR_ALIGN = 2'b10;
    localparam logic [1:0] ERR_COLL  = 2'b11;

endpackage
`default_nettype wire

// File: rtl/maple_line_sync.sv
`default_nettype none
// ============================================================================
// Module   : maple_line_sync
// Purpose  : Two-flop synchronizer plus edge detector for both Maple lines.
//            Flops reset to 1 because the bus idles high, so leaving reset
//            never produces a spurious falling edge.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            pin1, pin5    - raw asynchronous SDCKA / SDCKB
//            s1, s5        - synchronized levels
//            f1, f5        - falling edges (one clk wide)
//            r1, r5        - rising edges (one clk wide)
// Revision : 1.0 - initial release
// ============================================================================
module maple_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic pin1,
    input  logic pin5,
    output logic s1,
    output logic s5,
    output logic f1,
    output logic f5,
    output logic r1,
    output logic r5
);

    // [0] first metastability flop, [1] synced level, [2] previous synced level
    logic [2:0] r_p1;
    logic [2:0] r_p5;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_p1 <= 3'b111;
            r_p5 <= 3'b111;
        end else begin
            r_p1 <= {r_p1[1:0], pin1};
            r_p5 <= {r_p5[1:0], pin5};
        end
    end

    assign s1 = r_p1[1];
    assign s5 = r_p5[1];
    assign f1 =  r_p1[2] & ~r_p1[1];
    assign f5 =  r_p5[2] & ~r_p5[1];
    assign r1 = ~r_p1[2] &  r_p1[1];
    assign r5 = ~r_p5[2] &  r_p5[1];

endmodule
`default_nettype wire

// File: rtl/maple_in.sv
`default_nettype none
// ============================================================================
// Module   : maple_in
// Purpose  : Maple bus receiver. Detects the start pattern, decodes MSB-first
//            bytes from alternating pin1/pin5 falling edges, detects the end
//            pattern, pushes bytes to the receive FIFO and reports frame
//            start / end / abort events.
// Ports    : clk, rst             - clock, synchronous active-high reset
//            pin1, pin5           - raw SDCKA / SDCKB
//            oe                   - transmitter driving; forces IDLE
//            tick                 - bus-time strobe (timeout build only)
//            fifo_data/push/full  - receive FIFO write side
//            frame_start/end/err  - one-cycle event pulses
//            err_code             - code of last abort (held)
//            overflow             - sticky byte-dropped flag
// Config   : MAPLE_IN_TIMEOUT_EN  - enables the in-frame inactivity timeout
//                                   of TIMEOUT_TICKS tick pulses
// Revision : 1.0 - initial release
// ============================================================================
module maple_in
    import maple_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pin1,
    input  logic       pin5,
    input  logic       oe,
    input  logic       tick,
    output logic [7:0] fifo_data,
    output logic       fifo_push,
    input  logic       fifo_full,
    output logic       frame_start,
    output logic       frame_end,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       overflow
);

    logic w_s1, w_s5, w_f1, w_f5, w_r1, w_r5;

    maple_line_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .pin1 (pin1),
        .pin5 (pin5),
        .s1   (w_s1),
        .s5   (w_s5),
        .f1   (w_f1),
        .f5   (w_f5),
        .r1   (w_r1),
        .r5   (w_r5)
    );

    state_t     r_state, w_state_nxt;
    logic [2:0] r_pcnt,  w_pcnt_nxt;
    logic [2:0] r_bcnt,  w_bcnt_nxt;
    logic [7:0] r_byte,  w_byte_nxt;
    logic [7:0] r_data,  w_data_nxt;
    logic [1:0] r_code,  w_code_nxt;
    logic       r_ovf,   w_ovf_nxt;
    logic       r_push,  w_push_nxt;
    logic       r_start, w_start_nxt;
    logic       r_end,   w_end_nxt;
    logic       r_err,   w_err_nxt;
    logic [7:0] w_shift;
    logic       w_coll;
    logic       w_tmo_hit;

    assign w_coll = w_f1 & w_f5;

`ifdef MAPLE_IN_TIMEOUT_EN
    logic [15:0] r_tmo;
    logic        w_any_edge;

    assign w_any_edge = w_f1 | w_f5 | w_r1 | w_r5;
    // An edge in the same cycle as a tick restarts the wait rather than
    // completing it.
    assign w_tmo_hit  = tick && !w_any_edge &&
                        (r_tmo == 16'(TIMEOUT_TICKS - 1));

    always_ff @(posedge clk) begin
        if (rst || oe || (r_state == ST_IDLE) || w_any_edge) begin
            r_tmo <= 16'd0;
        end else if (tick) begin
            r_tmo <= r_tmo + 16'd1;
        end
    end
`else
    logic w_unused;
    assign w_unused  = tick | (TIMEOUT_TICKS == 0);
    assign w_tmo_hit = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_pcnt_nxt  = r_pcnt;
        w_bcnt_nxt  = r_bcnt;
        w_byte_nxt  = r_byte;
        w_data_nxt  = r_data;
        w_code_nxt  = r_code;
        w_ovf_nxt   = r_ovf;
        w_push_nxt  = 1'b0;
        w_start_nxt = 1'b0;
        w_end_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        w_shift     = {r_byte[6:0], w_s1};

        if (oe) begin
            w_state_nxt = ST_IDLE;
        end else if ((r_state != ST_IDLE) && (w_coll || w_tmo_hit)) begin
            w_state_nxt = ST_IDLE;
            w_err_nxt   = 1'b1;
            w_code_nxt  = ERR_COLL;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_f1 && w_s5) begin
                        w_state_nxt = ST_START;
                        w_pcnt_nxt  = 3'd0;
                    end
                end
                ST_START: begin
                    if (w_r1) begin
                        if (r_pcnt == START_PULSES) begin
                            w_start_nxt = 1'b1;
                            w_code_nxt  = ERR_NONE;
                            w_ovf_nxt   = 1'b0;
                            w_bcnt_nxt  = 3'd0;
                            w_byte_nxt  = 8'h00;
                            w_state_nxt = ST_DATA_A;
                        end else begin
                            w_err_nxt   = 1'b1;
                            w_code_nxt  = ERR_START;
                            w_state_nxt = ST_IDLE;
                        end
                    end else if (w_f5 && (r_pcnt != 3'd7)) begin
                        w_pcnt_nxt = r_pcnt + 3'd1;
                    end
                end
                ST_DATA_A: begin
                    if (w_f1) begin
                        w_byte_nxt  = {r_byte[6:0], w_s5};
                        w_bcnt_nxt  = r_bcnt + 3'd1;
                        w_state_nxt = ST_DATA_B;
                    end
                end
                ST_DATA_B: begin
                    if (w_f1) begin
                        // Second f1 in a row is the end marker. r_bcnt already
                        // counts the bit taken by the previous f1, so a byte
                        // boundary before that f1 shows up here as 1.
                        if (r_bcnt == 3'd1) begin
                            w_state_nxt = ST_END_WAIT;
                        end else begin
                            w_err_nxt   = 1'b1;
                            w_code_nxt  = ERR_ALIGN;
                            w_state_nxt = ST_IDLE;
                        end
                    end else if (w_f5) begin
                        w_byte_nxt  = w_shift;
                        w_bcnt_nxt  = r_bcnt + 3'd1;   // wraps 7 -> 0
                        w_state_nxt = ST_DATA_A;
                        if (r_bcnt == 3'd7) begin
                            if (fifo_full) begin
                                w_ovf_nxt  = 1'b1;
                            end else begin
                                w_push_nxt = 1'b1;
                                w_data_nxt = w_shift;
                            end
                        end
                    end
                end
                ST_END_WAIT: begin
                    if (w_r5) begin
                        w_end_nxt   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_pcnt  <= 3'd0;
            r_bcnt  <= 3'd0;
            r_byte  <= 8'h00;
            r_data  <= 8'h00;
            r_code  <= ERR_NONE;
            r_ovf   <= 1'b0;
            r_push  <= 1'b0;
            r_start <= 1'b0;
            r_end   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pcnt  <= w_pcnt_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_byte  <= w_byte_nxt;
            r_data  <= w_data_nxt;
            r_code  <= w_code_nxt;
            r_ovf   <= w_ovf_nxt;
            r_push  <= w_push_nxt;
            r_start <= w_start_nxt;
            r_end   <= w_end_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign fifo_data   = r_data;
    assign fifo_push   = r_push;
    assign frame_start = r_start;
    assign frame_end   = r_end;
    assign frame_err   = r_err;
    assign err_code    = r_code;
    assign overflow    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_maple_in.sv
`default_nettype none
// ============================================================================
// Module   : tb_maple_in
// Purpose  : Directed self-checking bench for maple_in. Drives Maple frames
//            bit by bit on pin1/pin5, collects pulses with a monitor and
//            checks event counts, pushed bytes and status flags.
// Revision : 1.0 - initial release
// ============================================================================
module tb_maple_in;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pin1 = 1'b1;
    logic       pin5 = 1'b1;
    logic       oe = 1'b0;
    logic       tick = 1'b0;
    logic       fifo_full = 1'b0;
    logic [7:0] fifo_data;
    logic       fifo_push, frame_start, frame_end, frame_err, overflow;
    logic [1:0] err_code;

    int n_chk  = 0;
    int n_fail = 0;
    int n_push = 0, n_start = 0, n_end = 0, n_err = 0, n_multi = 0;
    int b_push, b_start, b_end, b_err;
    logic [7:0] pd[$];

    always #5 clk = ~clk;

    maple_in #(.TIMEOUT_TICKS(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .pin1        (pin1),
        .pin5        (pin5),
        .oe          (oe),
        .tick        (tick),
        .fifo_data   (fifo_data),
        .fifo_push   (fifo_push),
        .fifo_full   (fifo_full),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .frame_err   (frame_err),
        .err_code    (err_code),
        .overflow    (overflow)
    );

    always @(negedge clk) begin
        if (fifo_push) begin
            n_push = n_push + 1;
            pd.push_back(fifo_data);
        end
        if (frame_start) n_start = n_start + 1;
        if (frame_end)   n_end   = n_end + 1;
        if (frame_err)   n_err   = n_err + 1;
        if ((int'(fifo_push) + int'(frame_start) + int'(frame_end) + int'(frame_err)) > 1)
            n_multi = n_multi + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] got(input int i);
        if (i < pd.size()) return {24'h0, pd[i]};
        return 32'hxxxxxxxx;
    endfunction

    task automatic step();
        repeat (4) @(negedge clk);
    endtask
    task automatic set1(input logic v); pin1 = v; step(); endtask
    task automatic set5(input logic v); pin5 = v; step(); endtask

    task automatic settle();
        repeat (6) @(negedge clk);
        #1;
    endtask

    task automatic snap();
        b_push = n_push; b_start = n_start; b_end = n_end; b_err = n_err;
    endtask

    task automatic start_pat(input int n);
        set1(1'b0);
        repeat (n) begin set5(1'b0); set5(1'b1); end
        set1(1'b1);
    endtask

    // Phase A: pin1 falls, pin5 carries the bit. Phase B: pin5 falls, pin1 carries it.
    task automatic send_bits(input logic [7:0] v, input int n);
        logic ph_a;
        ph_a = 1'b1;
        for (int i = 7; i > 7 - n; i--) begin
            if (ph_a) begin set5(v[i]); set1(1'b1); set1(1'b0); end
            else      begin set1(v[i]); set5(1'b1); set5(1'b0); end
            ph_a = ~ph_a;
        end
    endtask

    task automatic end_pat();
        set5(1'b0); set1(1'b1); set1(1'b0); set1(1'b1); set1(1'b0);
        set5(1'b1); set1(1'b1);
    endtask

    task automatic pulse_tick();
        tick = 1'b1; @(negedge clk);
        tick = 1'b0; @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_push",  fifo_push,   1'b0);
        chk("rst_start", frame_start, 1'b0);
        chk("rst_end",   frame_end,   1'b0);
        chk("rst_err",   frame_err,   1'b0);
        chk("rst_code",  err_code,    2'b00);
        chk("rst_ovf",   overflow,    1'b0);
        chk("rst_data",  fifo_data,   8'h00);
        step();

        // Clean two-byte frame
        snap();
        start_pat(4); send_bits(8'hA5, 8); send_bits(8'h3C, 8); end_pat(); settle();
        chk("t1_start", n_start - b_start, 1);
        chk("t1_push",  n_push - b_push,   2);
        chk("t1_b0",    got(b_push),       8'hA5);
        chk("t1_b1",    got(b_push + 1),   8'h3C);
        chk("t1_end",   n_end - b_end,     1);
        chk("t1_err",   n_err - b_err,     0);
        chk("t1_code",  err_code,          2'b00);
        chk("t1_data",  fifo_data,         8'h3C);

        // Three start pulses: bad start, following zero bits ignored
        snap();
        start_pat(3); settle();
        chk("t2_err",   n_err - b_err,     1);
        chk("t2_code",  err_code,          2'b01);
        send_bits(8'h00, 8); set5(1'b1); set1(1'b1); settle();
        chk("t2_start", n_start - b_start, 0);
        chk("t2_push",  n_push - b_push,   0);
        chk("t2_err2",  n_err - b_err,     1);

        // Five data bits then end pattern: misaligned end
        snap();
        start_pat(4); send_bits(8'b1011_0000, 5); end_pat(); settle();
        chk("t3_start", n_start - b_start, 1);
        chk("t3_err",   n_err - b_err,     1);
        chk("t3_code",  err_code,          2'b10);
        chk("t3_push",  n_push - b_push,   0);
        chk("t3_end",   n_end - b_end,     0);

        // FIFO full during the second of three bytes
        snap();
        start_pat(4);
        #1;
        chk("t4_code_clr", err_code, 2'b00);
        send_bits(8'h11, 8);
        fifo_full = 1'b1; send_bits(8'h22, 8); fifo_full = 1'b0;
        send_bits(8'h33, 8); end_pat(); settle();
        chk("t4_push", n_push - b_push, 2);
        chk("t4_b0",   got(b_push),     8'h11);
        chk("t4_b1",   got(b_push + 1), 8'h33);
        chk("t4_ovf",  overflow,        1'b1);
        chk("t4_end",  n_end - b_end,   1);

        // Transmitter owns the bus for a whole frame, then drops oe mid-frame
        snap();
        oe = 1'b1;
        start_pat(4); send_bits(8'hA5, 8); end_pat();
        start_pat(4); send_bits(8'h00, 4);
        oe = 1'b0;
        send_bits(8'h00, 4); end_pat(); settle();
        chk("t5_start", n_start - b_start, 0);
        chk("t5_push",  n_push - b_push,   0);
        chk("t5_end",   n_end - b_end,     0);
        chk("t5_err",   n_err - b_err,     0);
        chk("t5_ovf",   overflow,          1'b1);
        snap();
        start_pat(4); send_bits(8'h5A, 8); end_pat(); settle();
        chk("t5_start2", n_start - b_start, 1);
        chk("t5_b0",     got(b_push),       8'h5A);
        chk("t5_end2",   n_end - b_end,     1);
        chk("t5_ovf_clr", overflow,         1'b0);

        // Stall after three bits
        snap();
        start_pat(4); send_bits(8'b1010_0000, 3); settle();
        repeat (7) pulse_tick();
        repeat (3) @(negedge clk);
        #1;
        chk("t6_no_err_7", n_err - b_err, 0);
        pulse_tick();
        repeat (3) @(negedge clk);
        #1;
`ifdef MAPLE_IN_TIMEOUT_EN
        chk("t6_err_8",  n_err - b_err, 1);
        chk("t6_code",   err_code,      2'b11);
`else
        repeat (10) pulse_tick();
        settle();
        chk("t6_err_8",  n_err - b_err, 0);
        chk("t6_code",   err_code,      2'b00);
`endif

        // Reset mid-frame, then a clean recovery frame
        @(negedge clk);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        #1;
        chk("t7_code", err_code,  2'b00);
        chk("t7_ovf",  overflow,  1'b0);
        chk("t7_data", fifo_data, 8'h00);
        set1(1'b1); set5(1'b1);
        snap();
        start_pat(4); send_bits(8'h81, 8); end_pat(); settle();
        chk("t7_start", n_start - b_start, 1);
        chk("t7_b0",    got(b_push),       8'h81);
        chk("t7_end",   n_end - b_end,     1);
        chk("t7_err",   n_err - b_err,     0);

        chk("excl_pulses", n_multi, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
